// File: rtl/aha_tlx_lane_training_checker.sv
// Per-lane PRBS7 (x^7+x^6+1) training checker: self-seeded predictor, lock after LOCK_COUNT matches,
// saturating error counters, lock loss on LOSS_THRESHOLD consecutive errors. Optional AHA_TLX_CHK_LOOPBACK_EN adds TX_DATA.
module aha_tlx_lane_training_checker #(
    parameter int NUM_LANES      = 4,
    parameter int LOCK_COUNT     = 32,
    parameter int LOSS_THRESHOLD = 8,
    parameter int ERR_CNT_WIDTH  = 16
) (
    input  logic                                 CLK,
    input  logic                                 RESETn,
    input  logic [NUM_LANES-1:0]                 LANE_EN,
    input  logic [NUM_LANES-1:0]                 RX_DATA,
    input  logic                                 CLR_ERR,
`ifdef AHA_TLX_CHK_LOOPBACK_EN
    input  logic [NUM_LANES-1:0]                 LOOPBACK_SEL,
    output logic [NUM_LANES-1:0]                 TX_DATA,
`endif
    output logic [NUM_LANES-1:0]                 LOCKED,
    output logic                                 ALL_LOCKED,
    output logic [NUM_LANES*ERR_CNT_WIDTH-1:0]   ERR_COUNT,
    output logic [NUM_LANES-1:0]                 ERR_PULSE
);

    localparam logic [7:0] LOCK_LAST = 8'(LOCK_COUNT - 1);
    localparam logic [7:0] LOSS_LAST = 8'(LOSS_THRESHOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEED,
        ST_VERIFY,
        ST_LOCKED
    } lane_state_e;

    logic [NUM_LANES-1:0] lock_d_vec;
    logic                 all_locked_q;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_state_e              state_q;
        logic [6:0]               s_q;
        logic [2:0]               seed_cnt_q;
        logic [7:0]               match_cnt_q;
        logic [7:0]               cerr_cnt_q;
        logic                     locked_q;
        logic                     err_pulse_q;
        logic [ERR_CNT_WIDTH-1:0] err_cnt_q;
        logic                     pred;
        logic                     hit;
        logic                     verify_hit;
        logic                     lock_evt;
        logic                     loss_evt;
        logic                     err_evt;
        logic                     lock_d;

        assign pred       = s_q[6] ^ s_q[5];
        assign hit        = (RX_DATA[i] == pred);
        // An all-zero seed is the LFSR lock-up state; it matches a dead lane forever, so never trust it.
        assign verify_hit = hit && (s_q != 7'd0);
        assign lock_evt   = LANE_EN[i] && (state_q == ST_VERIFY) && verify_hit && (match_cnt_q == LOCK_LAST);
        assign err_evt    = LANE_EN[i] && (state_q == ST_LOCKED) && !hit;
        assign loss_evt   = err_evt && (cerr_cnt_q == LOSS_LAST);
        assign lock_d     = LANE_EN[i] && ((locked_q && !loss_evt) || lock_evt);

        always_ff @(posedge CLK or negedge RESETn) begin
            if (!RESETn) begin
                state_q     <= ST_IDLE;
                s_q         <= '0;
                seed_cnt_q  <= '0;
                match_cnt_q <= '0;
                cerr_cnt_q  <= '0;
                locked_q    <= 1'b0;
                err_pulse_q <= 1'b0;
                err_cnt_q   <= '0;
            end else begin
                locked_q    <= lock_d;
                err_pulse_q <= err_evt;
                if (CLR_ERR) begin
                    err_cnt_q <= '0;
                end else if (err_evt && (err_cnt_q != '1)) begin
                    err_cnt_q <= err_cnt_q + 1'b1;
                end

                if (!LANE_EN[i]) begin
                    state_q     <= ST_IDLE;
                    s_q         <= '0;
                    seed_cnt_q  <= '0;
                    match_cnt_q <= '0;
                    cerr_cnt_q  <= '0;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            state_q <= ST_SEED;
                        end
                        ST_SEED: begin
                            s_q <= {s_q[5:0], RX_DATA[i]};
                            if (seed_cnt_q == 3'd6) begin
                                seed_cnt_q  <= '0;
                                match_cnt_q <= '0;
                                state_q     <= ST_VERIFY;
                            end else begin
                                seed_cnt_q <= seed_cnt_q + 3'd1;
                            end
                        end
                        ST_VERIFY: begin
                            s_q <= {s_q[5:0], RX_DATA[i]};
                            if (verify_hit) begin
                                match_cnt_q <= match_cnt_q + 8'd1;
                                if (lock_evt) begin
                                    cerr_cnt_q <= '0;
                                    state_q    <= ST_LOCKED;
                                end
                            end else begin
                                seed_cnt_q  <= '0;
                                match_cnt_q <= '0;
                                state_q     <= ST_SEED;
                            end
                        end
                        ST_LOCKED: begin
                            // Free-running predictor: received errors never enter the shift register.
                            s_q <= {s_q[5:0], pred};
                            if (loss_evt) begin
                                cerr_cnt_q  <= '0;
                                seed_cnt_q  <= '0;
                                match_cnt_q <= '0;
                                state_q     <= ST_SEED;
                            end else if (err_evt) begin
                                cerr_cnt_q <= cerr_cnt_q + 8'd1;
                            end else begin
                                cerr_cnt_q <= '0;
                            end
                        end
                        default: begin
                            state_q <= ST_IDLE;
                        end
                    endcase
                end
            end
        end

`ifdef AHA_TLX_CHK_LOOPBACK_EN
        logic tx_q;

        always_ff @(posedge CLK or negedge RESETn) begin
            if (!RESETn) begin
                tx_q <= 1'b0;
            end else if (LOOPBACK_SEL[i]) begin
                tx_q <= RX_DATA[i];
            end else if (state_q == ST_LOCKED) begin
                tx_q <= pred;
            end else begin
                tx_q <= 1'b0;
            end
        end

        assign TX_DATA[i] = tx_q;
`endif

        assign lock_d_vec[i]                           = lock_d;
        assign LOCKED[i]                               = locked_q;
        assign ERR_PULSE[i]                            = err_pulse_q;
        assign ERR_COUNT[i*ERR_CNT_WIDTH +: ERR_CNT_WIDTH] = err_cnt_q;
    end

    // Uses next-state lock and current enables so it moves on the same edge as LOCKED.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            all_locked_q <= 1'b0;
        end else begin
            all_locked_q <= (|LANE_EN) && (&(lock_d_vec | ~LANE_EN));
        end
    end

    assign ALL_LOCKED = all_locked_q;

endmodule
